// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared FIFO types and width/legality helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    typedef enum logic {
        RD_ASYNC = 1'b0,
        RD_SYNC  = 1'b1
    } rd_lat_e;

    // Never returns 0, so pointer vectors stay legal for single-entry buffers.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat == 32'(RD_ASYNC)) || (lat == 32'(RD_SYNC));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_buf.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_buf
// Brief    : Circular prefetch buffer with registered head word output.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic                                rclk,
    input  logic                                rrstn,
    input  logic                                push,
    input  logic [DWIDTH-1:0]                   push_data,
    input  logic                                pop,
    input  logic                                flush,
    output logic                                m_valid,
    output logic [DWIDTH-1:0]                   m_data,
    output logic [clog2_min1(BUF_DEPTH+1)-1:0]  lvl
);

    localparam int PTR_W = clog2_min1(BUF_DEPTH);
    localparam int LVL_W = clog2_min1(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [LVL_W-1:0] C_LVL_FULL = LVL_W'(BUF_DEPTH);

    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DWIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic [DWIDTH-1:0] m_data_q, m_data_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        lvl_d  = lvl_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            lvl_d  = '0;
        end else begin
            if (push) begin
                mem_d[tail_q] = push_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   lvl_d = lvl_q + LVL_W'(1);
                2'b01:   lvl_d = lvl_q - LVL_W'(1);
                default: lvl_d = lvl_q;
            endcase
        end
        // The next head word is either already stored or is being written this cycle.
        m_data_d = (push && !flush && (tail_q == head_d)) ? push_data : mem_q[head_d];
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            mem_q    <= '{default: '0};
            head_q   <= '0;
            tail_q   <= '0;
            lvl_q    <= '0;
            m_data_q <= '0;
        end else begin
            mem_q    <= mem_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            lvl_q    <= lvl_d;
            m_data_q <= m_data_d;
        end
    end

    assign m_valid = (lvl_q != '0);
    assign m_data  = m_data_q;
    assign lvl     = lvl_q;

    assert property (@(posedge rclk) disable iff (!rrstn)
        !(push && !pop && (lvl_q == C_LVL_FULL)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Brief    : FIFO read-side consumer presenting a valid/ready output stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DWIDTH    = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2
) (
    input  logic                                rclk,
    input  logic                                rrstn,
    input  logic                                rempty,
    input  logic [DWIDTH-1:0]                   rdata,
    output logic                                rden,
    input  logic                                flush,
    output logic                                m_valid,
    output logic [DWIDTH-1:0]                   m_data,
    input  logic                                m_ready,
    output logic [clog2_min1(BUF_DEPTH+1)-1:0]  lvl
);

    localparam int LVL_W = clog2_min1(BUF_DEPTH + 1);
    localparam int SUM_W = LVL_W + 1;
    localparam logic [SUM_W-1:0] C_DEPTH = SUM_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        BLANK_0 = 2'd0,
        BLANK_1 = 2'd1,
        RUN     = 2'd2
    } blank_state_e;

    blank_state_e     state_q, state_d;
    logic [SUM_W-1:0] inflight;
    logic [SUM_W-1:0] occ;
    logic             pop_out;
    logic             land;
    logic             land_drop;
    logic             push;

    if (!rd_lat_legal(RD_LAT) || (BUF_DEPTH < 1)) begin : g_param_check
        $error("fifo_rd_stream: RD_LAT must be 0 or 1 and BUF_DEPTH at least 1");
    end

    always_ff @(posedge rclk or negedge rrstn) begin
        if (!rrstn) begin
            state_q <= BLANK_0;
        end else begin
            state_q <= state_d;
        end
    end

    // rempty is not trusted until two edges after reset release.
    always_comb begin
        state_d = state_q;
        pop_out = m_valid && m_ready;
        occ     = {1'b0, lvl} + inflight - SUM_W'(pop_out);
        case (state_q)
            BLANK_0: state_d = BLANK_1;
            BLANK_1: state_d = RUN;
            default: state_d = RUN;
        endcase
        rden = (state_q == RUN) && !flush && !rempty && (occ < C_DEPTH);
    end

    if (RD_LAT > 0) begin : g_land_pipe
        logic [RD_LAT-1:0] vld_q, vld_d;
        logic [RD_LAT-1:0] drop_q, drop_d;

        // On flush every word already requested is tagged so it is discarded on arrival.
        always_comb begin
            vld_d  = (vld_q << 1) | RD_LAT'(rden);
            drop_d = flush ? (vld_q << 1) : (drop_q << 1);
        end

        always_ff @(posedge rclk or negedge rrstn) begin
            if (!rrstn) begin
                vld_q  <= '0;
                drop_q <= '0;
            end else begin
                vld_q  <= vld_d;
                drop_q <= drop_d;
            end
        end

        assign inflight  = SUM_W'($countones(vld_q));
        assign land      = vld_q[RD_LAT-1];
        assign land_drop = drop_q[RD_LAT-1];
    end else begin : g_no_pipe
        assign inflight  = '0;
        assign land      = rden;
        assign land_drop = 1'b0;
    end

    assign push = land && !land_drop && !flush;

    fifo_rd_buf #(
        .DWIDTH    (DWIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .rclk      (rclk),
        .rrstn     (rrstn),
        .push      (push),
        .push_data (rdata),
        .pop       (pop_out),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .lvl       (lvl)
    );

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Brief    : Directed bench for fifo_rd_stream in three latency/depth setups.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rrstn;
    logic       rempty0, rempty1, rempty2;
    logic       rden0, rden1, rden2;
    logic       flush0, flush1, flush2;
    logic       m_ready0, m_ready1, m_ready2;
    logic       m_valid0, m_valid1, m_valid2;
    logic [7:0] rdata0, rdata1, rdata2;
    logic [7:0] m_data0, m_data1, m_data2;
    logic [0:0] lvl0;
    logic [1:0] lvl1, lvl2;

    logic [7:0] fmem [3][256];
    logic [7:0] wr_ptr [3];
    logic [7:0] rd_ptr [3] = '{default: 8'd0};

    int checks   = 0;
    int failures = 0;

    // FIFO models: dut0 has an asynchronous read, dut1/dut2 a registered read.
    always @(posedge clk) begin
        if (rden0) rd_ptr[0] <= rd_ptr[0] + 8'd1;
        if (rden1) rd_ptr[1] <= rd_ptr[1] + 8'd1;
        if (rden2) rd_ptr[2] <= rd_ptr[2] + 8'd1;
        if (rden1) rdata1 <= fmem[1][rd_ptr[1]];
        if (rden2) rdata2 <= fmem[2][rd_ptr[2]];
    end
    assign rdata0  = fmem[0][rd_ptr[0]];
    assign rempty0 = (wr_ptr[0] == rd_ptr[0]);
    assign rempty1 = (wr_ptr[1] == rd_ptr[1]);
    assign rempty2 = (wr_ptr[2] == rd_ptr[2]);

    fifo_rd_stream #(.DWIDTH(8), .RD_LAT(0), .BUF_DEPTH(1)) dut0 (
        .rclk(clk), .rrstn(rrstn), .rempty(rempty0), .rdata(rdata0), .rden(rden0),
        .flush(flush0), .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready0), .lvl(lvl0));

    fifo_rd_stream #(.DWIDTH(8), .RD_LAT(1), .BUF_DEPTH(2)) dut1 (
        .rclk(clk), .rrstn(rrstn), .rempty(rempty1), .rdata(rdata1), .rden(rden1),
        .flush(flush1), .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready1), .lvl(lvl1));

    fifo_rd_stream #(.DWIDTH(8), .RD_LAT(1), .BUF_DEPTH(3)) dut2 (
        .rclk(clk), .rrstn(rrstn), .rempty(rempty2), .rdata(rdata2), .rden(rden2),
        .flush(flush2), .m_valid(m_valid2), .m_data(m_data2), .m_ready(m_ready2), .lvl(lvl2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] k, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[k][wr_ptr[k]] = first + 8'(i);
            wr_ptr[k] = wr_ptr[k] + 8'd1;
        end
    endtask

    task automatic test_reset();
        int first_rden = -1;
        int first_vld  = -1;
        int got        = 0;
        rrstn    = 1'b0;
        m_ready1 = 1'b1;
        tick();
        checks++;
        if (m_valid1 !== 1'b0 || lvl1 !== 2'd0 || m_data1 !== 8'h00 || rden1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: m_valid=%b lvl=%0d m_data=%h rden=%b, expected 0 0 00 0",
                     m_valid1, lvl1, m_data1, rden1);
        end
        checks++;
        if (m_valid0 !== 1'b0 || lvl0 !== 1'b0 || m_valid2 !== 1'b0 || lvl2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_state_other: m_valid0=%b lvl0=%0d m_valid2=%b lvl2=%0d, expected all 0",
                     m_valid0, lvl0, m_valid2, lvl2);
        end
        load(2'd1, 8'h11, 1);
        load(2'd1, 8'h22, 1);
        load(2'd1, 8'h33, 1);
        rrstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rden1 && first_rden < 0) first_rden = i;
            if (m_valid1 && first_vld < 0) first_vld = i;
            if (i < 2) begin
                checks++;
                if (rden1 !== 1'b0) begin
                    failures++;
                    $display("FAIL blank_rden cycle %0d: rden=%b, expected 0", i, rden1);
                end
            end
            if (m_valid1 && m_ready1) begin
                checks++;
                if (got >= 3 || m_data1 !== 8'(17 * (got + 1))) begin
                    failures++;
                    $display("FAIL reset_stream word %0d: data=%h, expected %h", got, m_data1, 8'(17 * (got + 1)));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (first_rden != 2 || first_vld != 4) begin
            failures++;
            $display("FAIL reset_latency: first rden cycle=%0d first valid cycle=%0d, expected 2 and 4",
                     first_rden, first_vld);
        end
        checks++;
        if (got != 3) begin
            failures++;
            $display("FAIL reset_count: received %0d words, expected 3", got);
        end
    endtask

    task automatic test_stream();
        int first = -1;
        int last  = -1;
        int nv    = 0;
        int got   = 0;
        m_ready1 = 1'b1;
        load(2'd1, 8'h00, 16);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (m_valid1) begin
                if (first < 0) first = i;
                last = i;
                nv++;
                checks++;
                if (m_data1 !== 8'(got)) begin
                    failures++;
                    $display("FAIL stream_data word %0d: data=%h, expected %h", got, m_data1, 8'(got));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (nv != 16 || (last - first + 1) != 16) begin
            failures++;
            $display("FAIL stream_bubbles: valid cycles=%0d span=%0d, expected 16 and 16", nv, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        load(2'd1, 8'h40, 8);
        for (int i = 0; i < 36; i++) begin
            m_ready1 = !(i >= 4 && i < 14);
            @(negedge clk);
            if (i >= 4 && i < 14) begin
                checks++;
                if (rden1 !== 1'b0 || m_valid1 !== 1'b1 || m_data1 !== 8'h42) begin
                    failures++;
                    $display("FAIL bp_hold cycle %0d: rden=%b m_valid=%b m_data=%h, expected 0 1 42",
                             i, rden1, m_valid1, m_data1);
                end
            end
            if (i == 13) begin
                checks++;
                if (lvl1 !== 2'd2) begin
                    failures++;
                    $display("FAIL bp_lvl: lvl=%0d, expected 2", lvl1);
                end
            end
            if (m_valid1 && m_ready1) begin
                checks++;
                if (m_data1 !== 8'h40 + 8'(got)) begin
                    failures++;
                    $display("FAIL bp_order word %0d: data=%h, expected %h", got, m_data1, 8'h40 + 8'(got));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8) begin
            failures++;
            $display("FAIL bp_count: received %0d words, expected 8", got);
        end
    endtask

    task automatic test_flush();
        int got = 0;
        logic [7:0] exp;
        load(2'd2, 8'h60, 8);
        for (int i = 0; i < 25; i++) begin
            m_ready2 = (i >= 3);
            flush2   = (i == 3);
            @(negedge clk);
            if (i == 3) begin
                checks++;
                if (lvl2 !== 2'd2 || m_valid2 !== 1'b1 || m_data2 !== 8'h60 || rden2 !== 1'b0) begin
                    failures++;
                    $display("FAIL flush_cycle: lvl=%0d m_valid=%b m_data=%h rden=%b, expected 2 1 60 0",
                             lvl2, m_valid2, m_data2, rden2);
                end
            end
            if (i == 4) begin
                checks++;
                if (lvl2 !== 2'd0 || m_valid2 !== 1'b0 || rden2 !== 1'b1) begin
                    failures++;
                    $display("FAIL after_flush: lvl=%0d m_valid=%b rden=%b, expected 0 0 1",
                             lvl2, m_valid2, rden2);
                end
            end
            if (m_valid2 && m_ready2) begin
                exp = (got == 0) ? 8'h60 : 8'h62 + 8'(got);
                checks++;
                if (m_data2 !== exp) begin
                    failures++;
                    $display("FAIL flush_order word %0d: data=%h, expected %h", got, m_data2, exp);
                end
                got++;
            end
            tick();
        end
        flush2 = 1'b0;
        checks++;
        if (got != 6) begin
            failures++;
            $display("FAIL flush_count: received %0d words, expected 6", got);
        end
    endtask

    task automatic test_fifo_empty();
        int got = 0;
        int nv  = 0;
        m_ready1 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i == 0) load(2'd1, 8'h70, 4);
            if (i == 8) load(2'd1, 8'h74, 4);
            @(negedge clk);
            if (i >= 4 && i < 8) begin
                checks++;
                if (rden1 !== 1'b0 || (i >= 6 && m_valid1 !== 1'b0)) begin
                    failures++;
                    $display("FAIL empty_gap cycle %0d: rden=%b m_valid=%b, expected 0 and %s",
                             i, rden1, m_valid1, (i >= 6) ? "0" : "any");
                end
            end
            if (m_valid1) nv++;
            if (m_valid1 && m_ready1) begin
                checks++;
                if (m_data1 !== 8'h70 + 8'(got)) begin
                    failures++;
                    $display("FAIL empty_order word %0d: data=%h, expected %h", got, m_data1, 8'h70 + 8'(got));
                end
                got++;
            end
            tick();
        end
        checks++;
        if (got != 8 || nv != 8) begin
            failures++;
            $display("FAIL empty_count: received %0d words over %0d valid cycles, expected 8 and 8", got, nv);
        end
    endtask

    task automatic test_rdlat0();
        m_ready0 = 1'b1;
        load(2'd0, 8'h80, 6);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (rden0 !== (i <= 5)) begin
                failures++;
                $display("FAIL rl0_rden cycle %0d: rden=%b, expected %b", i, rden0, (i <= 5));
            end
            if (i >= 1 && i <= 6) begin
                checks++;
                if (m_valid0 !== 1'b1 || m_data0 !== 8'h80 + 8'(i - 1)) begin
                    failures++;
                    $display("FAIL rl0_stream cycle %0d: m_valid=%b data=%h, expected 1 %h",
                             i, m_valid0, m_data0, 8'h80 + 8'(i - 1));
                end
            end
            tick();
        end
        m_ready0 = 1'b0;
        load(2'd0, 8'h90, 2);
        @(negedge clk);
        checks++;
        if (rden0 !== 1'b1) begin
            failures++;
            $display("FAIL rl0_issue: rden=%b, expected 1", rden0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rden0 !== 1'b0 || lvl0 !== 1'b1 || m_data0 !== 8'h90) begin
            failures++;
            $display("FAIL rl0_stall: rden=%b lvl=%0d data=%h, expected 0 1 90", rden0, lvl0, m_data0);
        end
        m_ready0 = 1'b1;
        #1;
        checks++;
        if (rden0 !== 1'b1) begin
            failures++;
            $display("FAIL rl0_comb_ready: rden=%b, expected 1", rden0);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m_valid0 !== 1'b1 || m_data0 !== 8'h91) begin
            failures++;
            $display("FAIL rl0_next: m_valid=%b data=%h, expected 1 91", m_valid0, m_data0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready1 = 1'b1;
        load(2'd1, 8'hA0, 4);
        tick();
        tick();
        tick();
        checks++;
        if (m_valid1 !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: m_valid=%b, expected 1", m_valid1);
        end
        rrstn = 1'b0;
        #1;
        checks++;
        if (m_valid1 !== 1'b0 || lvl1 !== 2'd0 || rden1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: m_valid=%b lvl=%0d rden=%b, expected 0 0 0", m_valid1, lvl1, rden1);
        end
        tick();
        rrstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rden1 !== (i == 2)) begin
                failures++;
                $display("FAIL mid_blank cycle %0d: rden=%b, expected %b", i, rden1, (i == 2));
            end
            tick();
        end
    endtask

    initial begin
        rrstn    = 1'b0;
        flush0   = 1'b0;
        flush1   = 1'b0;
        flush2   = 1'b0;
        m_ready0 = 1'b0;
        m_ready1 = 1'b0;
        m_ready2 = 1'b0;
        wr_ptr   = '{default: 8'd0};
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_fifo_empty();
        test_rdlat0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
